// File: rtl/fmap_pkg.sv
// Shared types and constants for the feature-map pad writer.
// No logic; no latency; no backpressure.
// Holds the state encoding, the pad word and the default word width.
package fmap_pkg;

    localparam int FMAP_DATA_WIDTH = 32;

    // +0.0 in IEEE-754 single precision
    localparam logic [31:0] FMAP_PAD_WORD = 32'h0;

    typedef enum logic [2:0] {
        ST_TOP    = 3'd0,
        ST_LEFT   = 3'd1,
        ST_DATA   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_BOTTOM = 3'd4
    } fmap_wr_state_t;

endpackage

// File: rtl/fmap_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Latency: a word written into an empty FIFO shows on data_out one cycle later.
// Backpressure: writes are ignored while full, reads are ignored while empty.
module fmap_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_dat,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_fire;
    logic                  rd_fire;

    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign usedw    = wr_ptr - rd_ptr;
    // Stale memory is masked so an empty FIFO always presents zero
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/featuremap_pad_writer.sv
// Wraps a raster feature map in a one-pixel zero border and queues it in a FWFT FIFO; optional FMAP_WR_OVERFLOW_EN adds a sticky overflow flag.
// Latency: a word written into an empty FIFO appears on data_out one cycle later.
// Backpressure: pad words stall while full; a pixel offered while in_ready=0 is dropped.
module featuremap_pad_writer
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int WIDTH      = 56,
    parameter int DEPTH      = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     in_ready,
    input  logic                     rdreq,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     frame_done
`ifdef FMAP_WR_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    localparam int COL_W = $clog2(WIDTH + 2);
    localparam int ROW_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
    localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIDTH - 1);

    fmap_wr_state_t        state, state_nx;
    logic [COL_W-1:0]      col, col_nx;
    logic [ROW_W-1:0]      row, row_nx;
    logic                  done_nx;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_dat;

    assign in_ready = (state == ST_DATA) & ~full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_TOP;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            col        <= col_nx;
            row        <= row_nx;
            frame_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        done_nx  = 1'b0;
        wr       = 1'b0;
        wr_dat   = DATA_WIDTH'(FMAP_PAD_WORD);
        case (state)
            ST_TOP, ST_BOTTOM: begin
                wr = ~full;
                if (wr) begin
                    if (col == COL_LAST) begin
                        col_nx   = '0;
                        state_nx = (state == ST_TOP) ? ST_LEFT : ST_TOP;
                        done_nx  = (state == ST_BOTTOM);
                    end else begin
                        col_nx = col + COL_W'(1);
                    end
                end
            end
            ST_LEFT: begin
                wr = ~full;
                if (wr) begin
                    col_nx   = col + COL_W'(1);
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                wr     = valid_in & ~full;
                wr_dat = data_in;
                if (wr) begin
                    col_nx = col + COL_W'(1);
                    if (col == COL_DATA_LAST) state_nx = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                wr = ~full;
                if (wr) begin
                    col_nx = '0;
                    if (row == ROW_LAST) begin
                        row_nx   = '0;
                        state_nx = ST_BOTTOM;
                    end else begin
                        row_nx   = row + ROW_W'(1);
                        state_nx = ST_LEFT;
                    end
                end
            end
            default: begin
                state_nx = ST_TOP;
                col_nx   = '0;
                row_nx   = '0;
            end
        endcase
    end

`ifdef FMAP_WR_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (valid_in & ~in_ready) overflow <= 1'b1;
    end
`endif

    fmap_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr),
        .wr_dat   (wr_dat),
        .rd_en    (rdreq),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .usedw    (usedw)
    );

endmodule

// File: doc/featuremap_pad_writer.md
# featuremap_pad_writer

Producer end of the per-channel feature-map FIFO that every `featuremap_conv2d_*_filter*` block consumes. It accepts the raster pixel stream of one filter's output feature map (`valid_out`/`data_out` of an upstream layer). It inserts the one-pixel zero border that the 3×3 convolution expects, producing a (WIDTH+2)×(WIDTH+2) stream. It buffers that stream in an internal first-word-fall-through FIFO and exposes it to the next layer as `data_out`/`empty`/`rdreq`.

## Interface
- `DATA_WIDTH`, default 32: word width, IEEE-754 single.
- `WIDTH`, default 56: unpadded feature-map side; padded side is WIDTH+2.
- `DEPTH`, default 128: FIFO depth in words; must be a power of 2 and ≥ 4.
- `clk` input, 1 bit: the only clock.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `valid_in` input, 1 bit: `data_in` carries a pixel.
- `data_in` input, DATA_WIDTH bits: pixel, raster order.
- `in_ready` output, 1 bit: pixel is accepted this cycle if `valid_in`=1.
- `rdreq` input, 1 bit: pop the head word; ignored when `empty`=1.
- `data_out` output, DATA_WIDTH bits: head word; 0 when `empty`=1.
- `empty` output, 1 bit: FIFO empty.
- `full` output, 1 bit: FIFO full.
- `usedw` output, $clog2(DEPTH)+1 bits: word count.
- `frame_done` output, 1 bit: one-cycle pulse when the last padded word of a frame is written.
- `overflow` output, 1 bit: sticky; present only with the macro (see Configuration).

## Operation
- FSM states, in order:
  - TOP: writes WIDTH+2 zero words.
  - LEFT: writes 1 zero word.
  - DATA: writes WIDTH input pixels.
  - RIGHT: writes 1 zero word.
  - BOTTOM: writes WIDTH+2 zero words.
- Transitions:
  - TOP → LEFT.
  - LEFT → DATA.
  - DATA → RIGHT.
  - RIGHT → LEFT while row < WIDTH−1; otherwise RIGHT → BOTTOM.
  - BOTTOM → TOP, starting the next frame.
- Counters: `col` counts 0..WIDTH+1 and `row` counts 0..WIDTH−1. Both advance only on a write.
- Write enable:
  - Pad states: `wr = ~full`. Pad words are generated autonomously and need no input.
  - DATA: `wr = valid_in & ~full`, and `in_ready = (state==DATA) & ~full`.
- A pixel with `valid_in`=1 and `in_ready`=0 is dropped and counters do not advance.
- FIFO pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit, and increment modulo 2·DEPTH.
  - `full` = MSBs differ and low bits equal.
  - `empty` = pointers equal.
- Full boundary: `full` is sampled before the edge. A simultaneous `rdreq` at full pops but does not enable a write that cycle.
- Empty boundary: at empty, a write and an ignored `rdreq` give `usedw`=1 next cycle.
- Data is never arithmetically modified; padding word is all-zero (+0.0).

## Timing
- All outputs registered or derived from registered pointers, with no input-to-output combinational path except `in_ready` ← `full`/state.
- Reset values:
  - State is TOP; `row`, `col` and pointers are 0.
  - `empty`=1, `full`=0, `usedw`=0, `data_out`=0.
  - `in_ready`=0, `frame_done`=0, `overflow`=0.
- First pad word is written on the first edge after reset release. `empty` falls one cycle later.
- A word written at edge N is visible on `data_out` after edge N if the FIFO was empty (one-cycle latency). Otherwise it appears behind the queued words.
- `frame_done` is high for the cycle after the final BOTTOM write.
- Reset asserted mid-frame clears the FIFO contents, state and counters immediately. The partial frame is discarded.

## Configuration
- `FMAP_WR_OVERFLOW_EN`, when defined:
  - Adds the `overflow` port.
  - `overflow` sets on any cycle with `valid_in & ~in_ready` and clears only on reset.
- When undefined: no port, no register; dropped pixels go unreported.

## Structure
- `fmap_pkg` holds:
  - the FSM state typedef `fmap_wr_state_t`;
  - `FMAP_PAD_WORD` = 32'h0;
  - the default `DATA_WIDTH`.
- Sub-module `fmap_sync_fifo` (DATA_WIDTH, DEPTH) contains the memory, pointers, `full`/`empty`/`usedw` and the FWFT read.
- The top contains the FSM, the counters and the write mux.

## Test plan
All scenarios use WIDTH=2 (16 words per frame) and DEPTH=8.
- **Reset:** hold `rst`=0 → `empty`=1, `full`=0, `usedw`=0, `data_out`=0, `in_ready`=0, `frame_done`=0.
- **Normal frame:** `rdreq`=1 always; pixels 1,2,3,4 offered with `valid_in` → read sequence is 0,0,0,0,0,1,2,0,0,3,4,0,0,0,0,0, followed by one `frame_done` pulse.
- **Fill to full:** `rdreq`=0; feed 1,2 → `usedw` reaches 8 after the RIGHT pad; `full`=1; `in_ready` stays 0 at the next row's DATA.
- **Drop and overflow:** drive `valid_in`=1 while `full` → pixel dropped, `usedw` stays 8, `overflow`=1 with the macro. Then pop one word → the next pixel is accepted.
- **Simultaneous read/write:** at full, `rdreq` plus a pending pad → `usedw` is 7 on the first edge and 8 on the next.
- **Reset mid-frame:** apply reset after 6 words → `empty`=1 immediately; after release the stream restarts with 4 top-pad zeros.
